// File: rtl/mips_core_pkg.sv
// ---------------------------------------------------------------------------
// mips_core_pkg
// Shared types for the memory access stage.
//   MemAccessType    : READ/WRITE encoding carried by reservation-station requests
//   mem_acc_state_t  : memory access unit FSM states
//   mem_acc_req_t    : latched request (action, address, data, ROB tag); the
//                      data field also holds the returned load data
// ---------------------------------------------------------------------------
package mips_core_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int ROB_TAG_W  = 4;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } MemAccessType;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        BCAST    = 2'd3
    } mem_acc_state_t;

    typedef struct packed {
        MemAccessType            action;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_DATA_W-1:0]   data;
        logic [ROB_TAG_W-1:0]    tag;
    } mem_acc_req_t;

endpackage

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Memory stage behind the memory reservation station. Takes one load or
// committed store at a time, runs the valid/ready handshake with the d-cache,
// and broadcasts load results on the CDB tagged with the ROB tag.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_action/in_addr/in_data/in_tag : request from reservation station
//   flush               : branch mispredict flush (affects loads only)
//   m_stall             : high whenever a request is in flight; upstream holds
//   cache_req_*         : d-cache request channel (valid/ready)
//   cache_rsp_valid/data: d-cache read response (single-cycle pulse)
//   cdb_valid/tag/data  : load result broadcast, held until cdb_grant
//   st_done             : pulse in the cycle a store is accepted by the cache
//
// The latched-request struct comes from the package, so the width parameters
// are expected to stay at their package defaults.
// ---------------------------------------------------------------------------
module mem_access_unit
    import mips_core_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_W,
    parameter int DATA_WIDTH = MEM_DATA_W,
    parameter int TAG_BITS   = ROB_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_action,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [TAG_BITS-1:0]   in_tag,
    input  logic                  flush,
    output logic                  m_stall,
    output logic                  cache_req_valid,
    input  logic                  cache_req_ready,
    output logic                  cache_req_we,
    output logic [ADDR_WIDTH-1:0] cache_req_addr,
    output logic [DATA_WIDTH-1:0] cache_req_wdata,
    input  logic                  cache_rsp_valid,
    input  logic [DATA_WIDTH-1:0] cache_rsp_data,
    output logic                  cdb_valid,
    output logic [TAG_BITS-1:0]   cdb_tag,
    output logic [DATA_WIDTH-1:0] cdb_data,
    input  logic                  cdb_grant,
    output logic                  st_done
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    mem_acc_state_t state;
    mem_acc_req_t   req;
    logic           squash;
    logic           req_hs;
    MemAccessType   in_act;

    assign in_act = MemAccessType'(in_action);
    assign req_hs = (state == REQ) && cache_req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            req    <= '0;
            squash <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    squash <= 1'b0;
                    // A load seen together with flush belongs to the wrong path;
                    // stores are already committed and always go through.
                    if (in_valid && !((in_act == READ) && flush)) begin
                        req.action <= in_act;
                        req.addr   <= in_addr;
                        req.data   <= in_data;
                        req.tag    <= in_tag;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // The cache request cannot be withdrawn, so a flushed load
                    // is only marked and still runs to its response.
                    if ((req.action == READ) && flush)
                        squash <= 1'b1;
                    if (cache_req_ready)
                        state <= (req.action == WRITE) ? IDLE : WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (flush)
                        squash <= 1'b1;
                    if (cache_rsp_valid) begin
                        req.data <= cache_rsp_data;
                        // Include this cycle's flush so a flush coincident
                        // with the response still kills the broadcast.
                        state    <= (squash || flush) ? IDLE : BCAST;
                    end
                end
                BCAST: begin
                    if (flush || cdb_grant)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_stall         = (state != IDLE);
    assign cache_req_valid = (state == REQ);
    assign cache_req_we    = (state == REQ) && (req.action == WRITE);
    assign cache_req_addr  = req.addr & WORD_MASK;
    assign cache_req_wdata = req.data;
    assign st_done         = req_hs && (req.action == WRITE);
    // Flush withdraws the broadcast in the same cycle it is seen.
    assign cdb_valid       = (state == BCAST) && !flush;
    assign cdb_tag         = req.tag;
    assign cdb_data        = req.data;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_CDB = 2;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_action = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        m_stall;
    logic        cache_req_valid;
    logic        cache_req_ready = 1'b0;
    logic        cache_req_we;
    logic [31:0] cache_req_addr;
    logic [31:0] cache_req_wdata;
    logic        cache_rsp_valid = 1'b0;
    logic [31:0] cache_rsp_data = '0;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_grant = 1'b0;
    logic        st_done;

    int compared = 0;
    int mismatched = 0;
    ev_t sb[$];

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_action(in_action), .in_addr(in_addr),
        .in_data(in_data), .in_tag(in_tag), .flush(flush), .m_stall(m_stall),
        .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
        .cache_req_we(cache_req_we), .cache_req_addr(cache_req_addr),
        .cache_req_wdata(cache_req_wdata), .cache_rsp_valid(cache_rsp_valid),
        .cache_rsp_data(cache_rsp_data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_grant(cdb_grant), .st_done(st_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_cmp(input int kind, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL sb_unexpected: got event kind %0d a=0x%0h b=0x%0h, expected none", kind, a, b);
        end else begin
            e = sb.pop_front();
            check("sb_kind", 64'(kind), 64'(e.kind));
            check("sb_a", 64'(a), 64'(e.a));
            if (e.kind != K_RD)
                check("sb_b", 64'(b), 64'(e.b));
        end
    endtask

    // Monitor: every cache handshake and CDB grant is matched against the scoreboard in order.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cache_req_valid && cache_req_ready) begin
                    pop_cmp(cache_req_we ? K_WR : K_RD, cache_req_addr, cache_req_wdata);
                    if (cache_req_we)
                        check("st_done_hs", 64'(st_done), 64'd1);
                end else if (st_done) begin
                    check("st_done_spurious", 64'(st_done), 64'd0);
                end
                if (cdb_valid && cdb_grant)
                    pop_cmp(K_CDB, 32'(cdb_tag), cdb_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [3:0] tag, input logic [31:0] data);
        sb.push_back('{K_RD, addr & ~32'd3, 32'd0});
        sb.push_back('{K_CDB, 32'(tag), data});
        in_valid = 1'b1; in_action = 1'b0; in_addr = addr; in_tag = tag;
        cache_req_ready = 1'b1; cdb_grant = 1'b1;
        adv();
        in_valid = 1'b0;
        @(negedge clk);
        check("ld_stall_req", 64'(m_stall), 64'd1);
        check("ld_req_valid", 64'(cache_req_valid), 64'd1);
        check("ld_req_we", 64'(cache_req_we), 64'd0);
        adv();
        cache_rsp_valid = 1'b1; cache_rsp_data = data;
        @(negedge clk);
        check("ld_stall_wait", 64'(m_stall), 64'd1);
        check("ld_cdb_early", 64'(cdb_valid), 64'd0);
        adv();
        cache_rsp_valid = 1'b0;
        @(negedge clk);
        check("ld_stall_bcast", 64'(m_stall), 64'd1);
        check("ld_cdb_valid", 64'(cdb_valid), 64'd1);
        adv();
        @(negedge clk);
        check("ld_idle_stall", 64'(m_stall), 64'd0);
        check("ld_idle_cdb", 64'(cdb_valid), 64'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input int delay, input logic flush_on);
        sb.push_back('{K_WR, addr & ~32'd3, data});
        in_valid = 1'b1; in_action = 1'b1; in_addr = addr; in_data = data;
        cache_req_ready = 1'b0; flush = flush_on;
        adv();
        in_valid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("st_req_valid", 64'(cache_req_valid), 64'd1);
            check("st_req_we", 64'(cache_req_we), 64'd1);
            check("st_req_addr", 64'(cache_req_addr), 64'(addr & ~32'd3));
            check("st_req_wdata", 64'(cache_req_wdata), 64'(data));
            check("st_done_early", 64'(st_done), 64'd0);
            adv();
        end
        cache_req_ready = 1'b1;
        @(negedge clk);
        check("st_done_pulse", 64'(st_done), 64'd1);
        adv();
        cache_req_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("st_idle_stall", 64'(m_stall), 64'd0);
        check("st_done_once", 64'(st_done), 64'd0);
        check("st_no_cdb", 64'(cdb_valid), 64'd0);
    endtask

    initial begin
        bit got;

        // Reset state
        adv(); adv();
        @(negedge clk);
        check("rst_stall", 64'(m_stall), 64'd0);
        check("rst_req_valid", 64'(cache_req_valid), 64'd0);
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_st_done", 64'(st_done), 64'd0);
        check("rst_req_addr", 64'(cache_req_addr), 64'd0);
        adv();
        rst_n = 1'b1;

        // Plain load
        do_load(32'h100, 4'd3, 32'hDEADBEEF);

        // Store with ready delayed two cycles, unaligned address
        do_store(32'h206, 32'h55, 2, 1'b0);

        // Flush while load waits for its response
        sb.push_back('{K_RD, 32'h300, 32'd0});
        in_valid = 1'b1; in_action = 1'b0; in_addr = 32'h300; in_tag = 4'd5;
        cache_req_ready = 1'b1;
        adv();
        in_valid = 1'b0;
        adv();
        cache_req_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("sq_cdb_flush", 64'(cdb_valid), 64'd0);
        adv();
        flush = 1'b0; cache_rsp_valid = 1'b1; cache_rsp_data = 32'h1234;
        @(negedge clk);
        check("sq_stall_rsp", 64'(m_stall), 64'd1);
        adv();
        cache_rsp_valid = 1'b0;
        @(negedge clk);
        check("sq_idle", 64'(m_stall), 64'd0);
        check("sq_no_cdb", 64'(cdb_valid), 64'd0);
        do_load(32'h104, 4'd6, 32'hCAFEF00D);

        // Flush during broadcast with grant withheld
        sb.push_back('{K_RD, 32'h108, 32'd0});
        cdb_grant = 1'b0; cache_req_ready = 1'b1;
        in_valid = 1'b1; in_action = 1'b0; in_addr = 32'h108; in_tag = 4'd7;
        adv();
        in_valid = 1'b0;
        adv();
        cache_rsp_valid = 1'b1; cache_rsp_data = 32'hA5A5A5A5;
        adv();
        cache_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bc_cdb_valid", 64'(cdb_valid), 64'd1);
            check("bc_cdb_tag", 64'(cdb_tag), 64'd7);
            check("bc_cdb_data", 64'(cdb_data), 64'hA5A5A5A5);
            adv();
        end
        flush = 1'b1;
        @(negedge clk);
        check("bc_flush_drop", 64'(cdb_valid), 64'd0);
        adv();
        flush = 1'b0;
        @(negedge clk);
        check("bc_flush_idle", 64'(m_stall), 64'd0);
        cdb_grant = 1'b1;

        // Flush has no effect on a store
        do_store(32'h40C, 32'h77, 1, 1'b1);

        // Load presented with flush in IDLE is dropped
        in_valid = 1'b1; in_action = 1'b0; in_addr = 32'h800; in_tag = 4'd1; flush = 1'b1;
        adv();
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("drop_stall", 64'(m_stall), 64'd0);
        check("drop_req_valid", 64'(cache_req_valid), 64'd0);

        // Back-to-back load then store, store held upstream under m_stall
        sb.push_back('{K_RD, 32'h700, 32'd0});
        sb.push_back('{K_CDB, 32'hA, 32'h11112222});
        sb.push_back('{K_WR, 32'h708, 32'h99});
        cache_req_ready = 1'b1; cdb_grant = 1'b1;
        in_valid = 1'b1; in_action = 1'b0; in_addr = 32'h700; in_tag = 4'hA;
        adv();
        in_action = 1'b1; in_addr = 32'h70A; in_data = 32'h99;
        adv();
        cache_rsp_valid = 1'b1; cache_rsp_data = 32'h11112222;
        adv();
        cache_rsp_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!m_stall) begin
                got = 1'b1;
                break;
            end
            adv();
        end
        check("b2b_reach_idle", 64'(got), 64'd1);
        adv();
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (st_done) begin
                got = 1'b1;
                break;
            end
            adv();
        end
        check("b2b_st_done", 64'(got), 64'd1);
        adv();
        cache_req_ready = 1'b0;

        // Reset during WAIT_RSP, then a stale response
        sb.push_back('{K_RD, 32'h600, 32'd0});
        cache_req_ready = 1'b1;
        in_valid = 1'b1; in_action = 1'b0; in_addr = 32'h600; in_tag = 4'd2;
        adv();
        in_valid = 1'b0;
        adv();
        rst_n = 1'b0;
        adv();
        @(negedge clk);
        check("mrst_stall", 64'(m_stall), 64'd0);
        check("mrst_req_valid", 64'(cache_req_valid), 64'd0);
        check("mrst_req_we", 64'(cache_req_we), 64'd0);
        check("mrst_req_addr", 64'(cache_req_addr), 64'd0);
        check("mrst_req_wdata", 64'(cache_req_wdata), 64'd0);
        check("mrst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("mrst_cdb_tag", 64'(cdb_tag), 64'd0);
        check("mrst_cdb_data", 64'(cdb_data), 64'd0);
        check("mrst_st_done", 64'(st_done), 64'd0);
        adv();
        rst_n = 1'b1; cache_rsp_valid = 1'b1; cache_rsp_data = 32'hBAD0BAD0;
        adv();
        cache_rsp_valid = 1'b0;
        @(negedge clk);
        check("stale_stall", 64'(m_stall), 64'd0);
        check("stale_cdb", 64'(cdb_valid), 64'd0);
        do_load(32'h10C, 4'd9, 32'h0BADF00D);

        adv(); adv();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
